l1d_downstream_req_arb: RTL

Parametrised downstream request arbiter between the L1D MSHR array and the CHI-style TXREQ link. It selects one pending MSHR request per cycle using round-robin arbitration, with an optional evict-first class priority and a starvation guard. It tracks link-layer credits in an internal counter and issues registered request flits with flitpend/flitv framing. Sits between the MSHR entries and the downstream interconnect port.

---
 rtl/l1d_downstream_req_arb.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/l1d_downstream_req_arb.sv
// Downstream request arbiter: round-robin selection over MSHR requests with
// optional evict-first priority and starvation guard, credit-gated TXREQ flits.
module l1d_downstream_req_arb #(
  parameter int         ENTRY_NUM  = 16,
  parameter int         ID_W       = $clog2(ENTRY_NUM),
  parameter int         ADDR_W     = 41,
  parameter int         MAX_CRD    = 15,
  parameter int         CRD_W      = $clog2(MAX_CRD + 1),
  parameter bit         EVICT_PRIO = 1'b1,
  parameter int         STARVE_MAX = 4,
  parameter logic [5:0] RD_OPCODE  = 6'h04,
  parameter logic [5:0] WR_OPCODE  = 6'h1d
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ENTRY_NUM-1:0]        in_vld,
  output logic [ENTRY_NUM-1:0]        in_rdy,
  input  logic [ENTRY_NUM-1:0]        in_evict,
  input  logic [ENTRY_NUM*ADDR_W-1:0] in_addr,
  output logic                        out_flitpend,
  output logic                        out_flitv,
  output logic [ID_W-1:0]             out_txnid,
  output logic [5:0]                  out_opcode,
  output logic [2:0]                  out_size,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [1:0]                  out_order,
  input  logic                        out_lcrdv,
  output logic [CRD_W-1:0]            crd_cnt,
  output logic                        crd_ovf
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);

  // Handshake: an entry holds in_vld/in_evict/in_addr stable until in_rdy is
  // high in a cycle; that cycle is the launch, the flit appears registered
  // on the following cycle, and the entry drops in_vld afterwards.

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ST_W-1:0]      starve_q, starve_d;
  logic [CRD_W-1:0]     crd_q, crd_d;
  logic                 ovf_q, ovf_d;

  logic [ENTRY_NUM-1:0] ev, rd, cand;
  logic                 rd_any, ev_any, starved, send, found;
  logic [ID_W-1:0]      win, idx;
  logic                 win_evict;
  logic [ADDR_W-1:0]    win_addr;

  always_comb begin
    ev      = in_vld & in_evict;
    rd      = in_vld & ~in_evict;
    rd_any  = |rd;
    ev_any  = |ev;
    starved = EVICT_PRIO && (starve_q == ST_W'(STARVE_MAX)) && rd_any;
    if (!EVICT_PRIO) begin
      cand = in_vld;
    end else if (starved) begin
      cand = rd;
    end else if (ev_any) begin
      cand = ev;
    end else begin
      cand = rd;
    end
    send = (|in_vld) && (crd_q != '0);
  end

  // First candidate at or above the pointer, wrapping through index 0.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      idx = ptr_q + ID_W'(i);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_evict = 1'b0;
    win_addr  = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (ID_W'(i) == win) begin
        win_evict = in_evict[i];
        win_addr  = in_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    in_rdy = '0;
    if (send) begin
      in_rdy[win] = 1'b1;
    end
  end

  assign out_flitpend = send;

  always_comb begin
    ptr_d    = send ? (win + ID_W'(1)) : ptr_q;
    starve_d = starve_q;
    if (!EVICT_PRIO) begin
      starve_d = '0;
    end else if (send) begin
      if (!rd_any || !win_evict) begin
        starve_d = '0;
      end else if (starve_q != ST_W'(STARVE_MAX)) begin
        starve_d = starve_q + ST_W'(1);
      end
    end
  end

  // A returned credit with no launch at a full counter is dropped and flagged.
  always_comb begin
    crd_d = crd_q;
    ovf_d = ovf_q;
    if (out_lcrdv && !send) begin
      if (crd_q == CRD_W'(MAX_CRD)) begin
        ovf_d = 1'b1;
      end else begin
        crd_d = crd_q + CRD_W'(1);
      end
    end else if (!out_lcrdv && send) begin
      crd_d = crd_q - CRD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      starve_q <= '0;
      crd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
      crd_q    <= crd_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flitv  <= 1'b0;
      out_txnid  <= '0;
      out_opcode <= '0;
      out_size   <= '0;
      out_addr   <= '0;
    end else if (send) begin
      out_flitv  <= 1'b1;
      out_txnid  <= win;
      out_opcode <= win_evict ? WR_OPCODE : RD_OPCODE;
      out_size   <= 3'b101;
      out_addr   <= win_addr;
    end else begin
      out_flitv  <= 1'b0;
      out_txnid  <= '0;
      out_opcode <= '0;
      out_size   <= '0;
      out_addr   <= '0;
    end
  end

  assign out_order = 2'b00;
  assign crd_cnt   = crd_q;
  assign crd_ovf   = ovf_q;

endmodule
